// File: rtl/cs_frame_scheduler.sv
// cs_frame_scheduler: sequencing controller for one compressed-sensing frame.
// Accepts N_COLS samples, walks the ternary Phi ROM column by column issuing
// add/subtract/skip commands to an external accumulator bank, then streams
// the M_ROWS accumulated measurements out over a valid/ready channel.
module cs_frame_scheduler #(
    parameter int unsigned N_COLS = 96,
    parameter int unsigned M_ROWS = 48,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ACC_W  = 12,
    localparam int unsigned RW    = (M_ROWS > 1) ? $clog2(M_ROWS) : 1,
    localparam int unsigned CW    = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_reset,
    input  logic              start,
    output logic              busy,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [RW-1:0]     coef_row,
    output logic [CW-1:0]     coef_col,
    input  logic [3:0]        coef_code,
    output logic              acc_clr,
    output logic              acc_we,
    output logic [RW-1:0]     acc_row,
    output logic              acc_sub,
    output logic [DATA_W-1:0] acc_data,
    output logic [RW-1:0]     acc_rd_row,
    input  logic [ACC_W-1:0]  acc_rd_data,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              frame_done
);

    localparam logic [RW-1:0] ROW_LAST = RW'(M_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);
    localparam logic [3:0]    CODE_POS = 4'b0001;
    localparam logic [3:0]    CODE_NEG = 4'b1001;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT,
        S_SCAN,
        S_DRAIN,
        S_READ,
        S_LOAD,
        S_OUT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     rd_q, rd_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [ACC_W-1:0]  out_data_q, out_data_d;
    // issue_q/acc_row_q delay the SCAN address by one cycle so the command
    // lines up with the registered ROM data arriving on coef_code.
    logic              issue_q, issue_d;
    logic [RW-1:0]     acc_row_q, acc_row_d;

    // State and datapath registers, synchronously cleared by reset.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            rd_q       <= '0;
            sample_q   <= '0;
            out_data_q <= '0;
            issue_q    <= 1'b0;
            acc_row_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            rd_q       <= rd_d;
            sample_q   <= sample_d;
            out_data_q <= out_data_d;
            issue_q    <= issue_d;
            acc_row_q  <= acc_row_d;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        rd_d       = rd_q;
        sample_d   = sample_q;
        out_data_d = out_data_q;
        issue_d    = (state_q == S_SCAN);
        acc_row_d  = row_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    col_d   = '0;
                end
            end
            S_CLEAR: state_d = S_WAIT;
            S_WAIT: begin
                if (in_valid) begin
                    sample_d = in_data;
                    row_d    = '0;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (row_q == ROW_LAST) begin
                    row_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            S_DRAIN: begin
                if (col_q == COL_LAST) begin
                    rd_d    = '0;
                    state_d = S_READ;
                end else begin
                    col_d   = col_q + CW'(1);
                    state_d = S_WAIT;
                end
            end
            S_READ: state_d = S_LOAD;
            S_LOAD: begin
                out_data_d = acc_rd_data;
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    if (rd_q == ROW_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        rd_d    = rd_q + RW'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from state and registered datapath.
    always_comb begin
        busy       = (state_q != S_IDLE);
        acc_clr    = (state_q == S_CLEAR);
        in_ready   = (state_q == S_WAIT);
        coef_row   = row_q;
        coef_col   = col_q;
        acc_we     = issue_q && ((coef_code == CODE_POS) || (coef_code == CODE_NEG));
        acc_sub    = issue_q && (coef_code == CODE_NEG);
        acc_row    = acc_row_q;
        acc_data   = sample_q;
        acc_rd_row = rd_q;
        out_valid  = (state_q == S_OUT);
        out_data   = out_data_q;
        out_last   = (state_q == S_OUT) && (rd_q == ROW_LAST);
        frame_done = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_cs_frame_scheduler.sv
// Directed bench for cs_frame_scheduler: ROM and accumulator bank models,
// a valid/ready source and sink, and a per-cycle compare process checking
// the DUT against measurements computed directly as sum(Phi[r][c] * x[c]).
module tb_cs_frame_scheduler;

    localparam int N  = 96;
    localparam int M  = 48;
    localparam int DW = 4;
    localparam int AW = 12;
    localparam int RW = 6;
    localparam int CW = 7;
    localparam int MIN_FRAME = 2 + N * (M + 2) + 3 * M + 1;

    logic          sys_clk = 1'b0;
    logic          sys_reset, start, busy;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_data;
    logic [RW-1:0] coef_row, acc_row, acc_rd_row;
    logic [CW-1:0] coef_col;
    logic [3:0]    coef_code;
    logic          acc_clr, acc_we, acc_sub;
    logic [DW-1:0] acc_data;
    logic [AW-1:0] acc_rd_data, out_data;
    logic          out_valid, out_last, out_ready, frame_done;

    cs_frame_scheduler #(.N_COLS(N), .M_ROWS(M), .DATA_W(DW), .ACC_W(AW)) dut (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .start(start), .busy(busy),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .coef_row(coef_row), .coef_col(coef_col), .coef_code(coef_code),
        .acc_clr(acc_clr), .acc_we(acc_we), .acc_row(acc_row), .acc_sub(acc_sub),
        .acc_data(acc_data), .acc_rd_row(acc_rd_row), .acc_rd_data(acc_rd_data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .frame_done(frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    // Frame configuration
    int rom_mode  = 0;
    int x_mul     = 1;
    int x_add     = 0;
    bit sparse_in = 0;
    bit stall_out = 0;

    function automatic int xval(int c);
        return (c * x_mul + x_add) % 16;
    endfunction

    function automatic int hsh(int r, int c);
        return (r * 7 + c * 3 + r * c) % 5;
    endfunction

    // Ternary matrix value at (r, c) for the current ROM mode
    function automatic int phi(int r, int c);
        if (rom_mode == 0) begin
            if (c == 2 * r) return 1;
            if (c == 2 * r + 1) return -1;
            return 0;
        end
        if (rom_mode == 1) return 0;
        if (hsh(r, c) == 0) return 1;
        if (hsh(r, c) == 1) return -1;
        return 0;
    endfunction

    // ROM contents, including non-canonical codes that must read as zero
    function automatic logic [3:0] rom_code(int r, int c);
        if (rom_mode == 0) begin
            if (phi(r, c) == 1) return 4'b0001;
            if (phi(r, c) == -1) return 4'b1001;
            return 4'b0000;
        end
        if (rom_mode == 1) return ((r + c) % 2 == 1) ? 4'b0101 : 4'b0000;
        case (hsh(r, c))
            0: return 4'b0001;
            1: return 4'b1001;
            2: return 4'b1111;
            3: return 4'b0011;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [AW-1:0] exp_meas(int r);
        int s = 0;
        for (int c = 0; c < N; c++) s += phi(r, c) * xval(c);
        return AW'(s);
    endfunction

    function automatic int nz_count();
        int n = 0;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                if (phi(r, c) != 0) n++;
        return n;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Registered coefficient ROM
    always @(posedge sys_clk) coef_code <= rom_code(int'(coef_row), int'(coef_col));

    // Accumulator bank with one-cycle read latency
    logic [AW-1:0] bank [64];
    always @(posedge sys_clk) begin
        if (acc_clr) begin
            for (int i = 0; i < 64; i++) bank[i] <= '0;
        end else if (acc_we) begin
            bank[acc_row] <= acc_sub ? bank[acc_row] - AW'(acc_data)
                                     : bank[acc_row] + AW'(acc_data);
        end
        acc_rd_data <= bank[acc_rd_row];
    end

    // Sample source: x[idx] presented, idx advances only on a handshake
    initial begin
        int src_idx = 0;
        bit hs, clr;
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            @(negedge sys_clk);
            hs  = in_valid && in_ready;
            clr = acc_clr;
            @(posedge sys_clk);
            #1;
            if (clr) src_idx = 0;
            else if (hs) src_idx++;
            in_valid = sparse_in ? (cyc % 7 == 0) : 1'b1;
            in_data  = in_valid ? DW'(xval(src_idx)) : DW'(xval(src_idx) + 5);
        end
    end

    // Measurement sink: ready high, or 3-cycle stalls with short ready runs
    initial begin
        int stall_left = 0;
        int run_left   = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge sys_clk);
            #1;
            if (!stall_out) begin
                out_ready = 1'b1;
            end else if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (run_left > 0) begin
                out_ready = 1'b1;
                run_left--;
            end else begin
                out_ready  = 1'b0;
                stall_left = 2;
                run_left   = $urandom_range(1, 3);
            end
        end
    end

    // Per-cycle compare process
    int consumed = 0, out_k = 0, since_hs = 0;
    int we_cnt = 0, clr_cnt = 0, out_cnt = 0, last_cnt = 0, done_cnt = 0;
    bit gap_active = 0, prev_stall = 0, prev_acc = 0, exp_done = 0;
    logic [AW-1:0] held_data, first_out;
    logic          held_last;

    initial begin
        forever begin
            @(negedge sys_clk);
            if (sys_reset) begin
                gap_active = 0; prev_stall = 0; prev_acc = 0; exp_done = 0;
                continue;
            end
            if (acc_clr) begin
                clr_cnt++;
                consumed   = 0;
                out_k      = 0;
                gap_active = 0;
            end
            // A sample occupies the scheduler for exactly M SCAN + 1 DRAIN cycles
            if (gap_active) begin
                since_hs++;
                check("in_ready_gap", in_ready, since_hs == M + 2);
                if (since_hs >= M + 2) gap_active = 0;
            end
            if (in_valid && in_ready) begin
                consumed++;
                since_hs   = 0;
                gap_active = (consumed < N);
            end
            if (acc_we) begin
                we_cnt++;
                check("acc_data", acc_data, xval(consumed - 1));
                check("acc_sign", acc_sub ? -1 : 1, phi(int'(acc_row), consumed - 1));
            end
            if (prev_acc) check("out_drop", out_valid, 0);
            if (prev_stall) begin
                check("out_hold_valid", out_valid, 1);
                check("out_hold_data", out_data, held_data);
                check("out_hold_last", out_last, held_last);
            end
            if (frame_done || exp_done) check("frame_done", frame_done, exp_done);
            if (frame_done) done_cnt++;
            exp_done = 0; prev_acc = 0; prev_stall = 0;
            if (out_valid && out_ready) begin
                out_cnt++;
                if (out_last) last_cnt++;
                if (out_k == 0) first_out = out_data;
                check("out_data", out_data, exp_meas(out_k));
                check("out_last", out_last, out_k == M - 1);
                out_k++;
                prev_acc = 1;
                exp_done = (out_k == M);
            end else if (out_valid) begin
                prev_stall = 1;
                held_data  = out_data;
                held_last  = out_last;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_acc_clr"}, acc_clr, 0);
        check({tag, "_acc_we"}, acc_we, 0);
        check({tag, "_acc_sub"}, acc_sub, 0);
        check({tag, "_acc_row"}, acc_row, 0);
        check({tag, "_acc_data"}, acc_data, 0);
        check({tag, "_acc_rd_row"}, acc_rd_row, 0);
        check({tag, "_coef_row"}, coef_row, 0);
        check({tag, "_coef_col"}, coef_col, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    task automatic pulse_start(output int k0);
        @(posedge sys_clk);
        #1 start = 1'b1;
        @(posedge sys_clk);
        #1 start = 1'b0;
        k0 = cyc;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge sys_clk);
            if (frame_done) begin
                dc = cyc;
                return;
            end
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic wait_neg(input string name, input int which);
        for (int i = 0; i < 20000; i++) begin
            @(negedge sys_clk);
            if (which == 0 && in_valid && in_ready) return;
            if (which == 1 && out_valid && out_ready) return;
            if (which == 2 && out_valid) return;
            if (which == 3 && consumed >= 41) return;
        end
        check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Directed stimulus
    initial begin
        int k0, dc, we0, clr0, oc0, lc0, dn0, nz;
        sys_reset = 1'b1;
        start     = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_all_zero("por");
        @(posedge sys_clk);
        #1 sys_reset = 1'b0;

        // Partial frame, reset in the middle of column 40's scan
        rom_mode = 0; x_mul = 1; x_add = 0;
        pulse_start(k0);
        wait_neg("col40", 3);
        repeat (10) @(negedge sys_clk);
        check("scan_col40", coef_col, 40);
        check("scan_busy", busy, 1);
        @(posedge sys_clk);
        #1 sys_reset = 1'b1;
        @(posedge sys_clk);
        #1 sys_reset = 1'b0;
        @(negedge sys_clk);
        check_all_zero("rst");
        repeat (3) @(negedge sys_clk);
        check("rst_idle_busy", busy, 0);

        // Identity-like frame after reset
        we0 = we_cnt; clr0 = clr_cnt; oc0 = out_cnt; lc0 = last_cnt; dn0 = done_cnt;
        pulse_start(k0);
        @(negedge sys_clk);
        check("a_clr", acc_clr, 1);
        check("a_busy", busy, 1);
        check("a_ready_early", in_ready, 0);
        @(negedge sys_clk);
        check("a_ready", in_ready, 1);
        check("a_clr_once", acc_clr, 0);
        @(negedge sys_clk);
        check("a_col0", coef_col, 0);
        check("a_row0", coef_row, 0);
        @(negedge sys_clk);
        check("a_row1", coef_row, 1);
        wait_done(dc);
        check("a_frame_len", dc - k0 + 2, MIN_FRAME);
        check("a_we_count", we_cnt - we0, 96);
        check("a_clr_count", clr_cnt - clr0, 1);
        check("a_out_count", out_cnt - oc0, 48);
        check("a_last_count", last_cnt - lc0, 1);
        check("a_first_out", first_out, 12'hFFF);
        check("a_done_count", done_cnt - dn0, 1);
        @(negedge sys_clk);
        check("a_busy_after", busy, 0);

        // Sparse input valid
        rom_mode = 2; x_mul = 5; x_add = 3; sparse_in = 1;
        nz = nz_count();
        we0 = we_cnt; oc0 = out_cnt;
        pulse_start(k0);
        wait_done(dc);
        sparse_in = 0;
        check("c_we_count", we_cnt - we0, nz);
        check("c_out_count", out_cnt - oc0, 48);
        check("c_slower", (dc - k0 + 2) > MIN_FRAME, 1);

        // Output back-pressure
        x_mul = 3; x_add = 7; stall_out = 1;
        we0 = we_cnt; oc0 = out_cnt; dn0 = done_cnt;
        pulse_start(k0);
        wait_done(dc);
        @(negedge sys_clk);
        stall_out = 0;
        check("d_out_count", out_cnt - oc0, 48);
        check("d_done_count", done_cnt - dn0, 1);
        check("d_we_count", we_cnt - we0, nz);

        // Stray start pulses in SCAN, READ and OUT
        x_mul = 7; x_add = 1;
        we0 = we_cnt; clr0 = clr_cnt; oc0 = out_cnt;
        pulse_start(k0);
        wait_neg("e_hs", 0);
        @(posedge sys_clk);
        #1 start = 1'b1;
        @(posedge sys_clk);
        #1 start = 1'b0;
        wait_neg("e_acc", 1);
        @(posedge sys_clk);
        #1 start = 1'b1;
        @(posedge sys_clk);
        #1 start = 1'b0;
        wait_neg("e_out", 2);
        start = 1'b1;
        @(posedge sys_clk);
        #1 start = 1'b0;
        wait_done(dc);
        check("e_frame_len", dc - k0 + 2, MIN_FRAME);
        check("e_clr_count", clr_cnt - clr0, 1);
        check("e_out_count", out_cnt - oc0, 48);
        check("e_we_count", we_cnt - we0, nz);

        // Back-to-back start the cycle after frame_done, all-zero ROM
        rom_mode = 1; x_mul = 1; x_add = 0;
        we0 = we_cnt; clr0 = clr_cnt; oc0 = out_cnt;
        pulse_start(k0);
        @(negedge sys_clk);
        check("b_restart_clr", acc_clr, 1);
        check("b_restart_busy", busy, 1);
        wait_done(dc);
        check("b_frame_len", dc - k0 + 2, MIN_FRAME);
        check("b_we_count", we_cnt - we0, 0);
        check("b_clr_count", clr_cnt - clr0, 1);
        check("b_out_count", out_cnt - oc0, 48);

        repeat (2) @(negedge sys_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
